// File: rtl/pc_predict_unit_pkg.sv
// Shared definitions for the fetch-stage next-PC predictor: address width,
// RISC-V control-flow opcodes, link-register test and immediate extraction.
package pc_predict_unit_pkg;

  localparam int ADDR_W = 32;

  localparam logic [6:0] B_TYPE = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  // Link registers recognised by the return-address stack.
  localparam logic [4:0] REG_RA = 5'd1;
  localparam logic [4:0] REG_T0 = 5'd5;

  // Coarse classification of the fetched instruction, exposed for debug.
  typedef enum logic [1:0] {
    CF_OTHER  = 2'd0,
    CF_BRANCH = 2'd1,
    CF_JAL    = 2'd2,
    CF_JALR   = 2'd3
  } cf_kind_e;

  function automatic cf_kind_e classify(input logic [6:0] opcode);
    cf_kind_e kind;
    case (opcode)
      B_TYPE:  kind = CF_BRANCH;
      JAL:     kind = CF_JAL;
      JALR:    kind = CF_JALR;
      default: kind = CF_OTHER;
    endcase
    return kind;
  endfunction

  function automatic logic is_link(input logic [4:0] r);
    return (r == REG_RA) || (r == REG_T0);
  endfunction

  // B-type offset, sign-extended, bit 0 always zero.
  function automatic logic [ADDR_W-1:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  // J-type offset, sign-extended, bit 0 always zero.
  function automatic logic [ADDR_W-1:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // I-type offset, sign-extended.
  function automatic logic [ADDR_W-1:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

endpackage

// File: rtl/pc_predict_unit_bht.sv
// Branch history table: one saturating counter per entry, combinational
// read port for the fetch lookup, one saturating update port for training.
// A read and a write to the same entry in one cycle returns the old value.
module pc_bht #(
  parameter int IDX_W = 8,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  output logic [CNT_W-1:0] rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q [ENTRIES];
  logic [CNT_W-1:0] wr_cur;
  logic [CNT_W-1:0] wr_next;

  assign rd_cnt   = cnt_q[rd_idx];
  assign rd_taken = rd_cnt[CNT_W-1];

  // Saturating increment/decrement of the trained entry.
  always_comb begin
    wr_cur  = cnt_q[wr_idx];
    wr_next = wr_cur;
    if (wr_taken) begin
      if (wr_cur != CNT_MAX) wr_next = wr_cur + CNT_ONE;
    end else begin
      if (wr_cur != CNT_ZERO) wr_next = wr_cur - CNT_ONE;
    end
  end

  // Counter array: every entry starts weakly taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
    end else if (wr_en) begin
      cnt_q[wr_idx] <= wr_next;
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch-stage next-PC generator. Predicts conditional branches with a BHT,
// follows JAL directly and predicts returns through a circular RAS.
// ROB mispredicts redirect the PC and flush the RAS.
//
// Handshake: there is no backpressure anywhere. fetch_valid and rob_valid
// are single-cycle qualifiers sampled on every rising clk edge; pc_valid is
// a one-cycle pulse meaning out_pc was produced on the preceding edge.
// A fetch is accepted only when rdy & fetch_valid and no redirect occurs.
module pc_predict_unit
  import pc_predict_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          IDX_W     = 8,
  parameter int          CNT_W     = 2,
  parameter int          RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  output logic [ADDR_W-1:0] out_pc,
  output logic              pc_valid,
  output logic              pred_taken,
  input  logic              fetch_valid,
  input  logic [31:0]       fetch_inst,
  input  logic              rob_valid,
  input  logic              rob_is_branch,
  input  logic [ADDR_W-1:0] rob_pc,
  input  logic              rob_taken,
  input  logic              rob_mispredict,
  input  logic [ADDR_W-1:0] rob_target
);

  localparam int SP_W      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int RAS_CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [RAS_CNT_W-1:0] RAS_FULL = RAS_CNT_W'(RAS_DEPTH);
  localparam logic [RAS_CNT_W-1:0] RAS_ONE  = RAS_CNT_W'(1);
  localparam logic [SP_W-1:0]      SP_ONE   = SP_W'(1);

  // Return-address stack: sp points at the next free slot, wraps naturally.
  logic [ADDR_W-1:0]    ras_q [RAS_DEPTH];
  logic [SP_W-1:0]      ras_sp_q;
  logic [RAS_CNT_W-1:0] ras_cnt_q;
  logic [ADDR_W-1:0]    ras_top;

  // Decode of the fetched instruction.
  logic [6:0]  opcode;
  logic [4:0]  inst_rd;
  logic [4:0]  inst_rs1;
  cf_kind_e    cf_kind;
  logic        is_return;
  logic [ADDR_W-1:0] pc_plus4;

  // Control for this cycle.
  logic        redirect;
  logic        fetch_go;
  logic [ADDR_W-1:0] fetch_next_pc;
  logic        fetch_taken;
  logic        ras_push;
  logic        ras_pop;

  // BHT interface.
  logic              bht_taken;
  logic [CNT_W-1:0]  bht_cnt;
  logic              bht_wr_en;

  logic unused_bits;

  assign opcode   = fetch_inst[6:0];
  assign inst_rd  = fetch_inst[11:7];
  assign inst_rs1 = fetch_inst[19:15];
  assign cf_kind  = classify(opcode);
  assign pc_plus4 = out_pc + 32'd4;
  assign ras_top  = ras_q[ras_sp_q - SP_ONE];

  // A return reads a link register with zero offset and either discards the
  // link (rd=x0) or relinks into the other link register (push+pop).
  assign is_return = is_link(inst_rs1) && (imm_i(fetch_inst) == '0) &&
                     ((inst_rd == 5'd0) || (is_link(inst_rd) && (inst_rd != inst_rs1)));

  assign redirect = rob_valid & rob_mispredict;
  assign fetch_go = rdy & fetch_valid & ~redirect;

  assign bht_wr_en = rob_valid & rob_is_branch;

  assign unused_bits = ^{rob_pc[ADDR_W-1:IDX_W+2], rob_pc[1:0], bht_cnt[CNT_W-2:0]};

  pc_bht #(
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (out_pc[IDX_W+1:2]),
    .rd_taken (bht_taken),
    .rd_cnt   (bht_cnt),
    .wr_en    (bht_wr_en),
    .wr_idx   (rob_pc[IDX_W+1:2]),
    .wr_taken (rob_taken)
  );

  // Next-PC selection and RAS intent for the fetched instruction.
  always_comb begin
    fetch_next_pc = pc_plus4;
    fetch_taken   = 1'b0;
    ras_push      = 1'b0;
    ras_pop       = 1'b0;
    case (cf_kind)
      CF_BRANCH: begin
        if (bht_taken) begin
          fetch_next_pc = out_pc + imm_b(fetch_inst);
          fetch_taken   = 1'b1;
        end
      end
      CF_JAL: begin
        fetch_next_pc = out_pc + imm_j(fetch_inst);
        fetch_taken   = 1'b1;
        ras_push      = is_link(inst_rd);
      end
      CF_JALR: begin
        ras_push = is_link(inst_rd);
        if (is_return && (ras_cnt_q != '0)) begin
          ras_pop       = 1'b1;
          fetch_next_pc = ras_top;
          fetch_taken   = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // PC register: redirect wins over fetch; pc_valid pulses per new PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_pc     <= RESET_PC;
      pc_valid   <= 1'b0;
      pred_taken <= 1'b0;
    end else if (redirect) begin
      out_pc     <= rob_target;
      pc_valid   <= 1'b1;
      pred_taken <= rob_taken;
    end else if (fetch_go) begin
      out_pc     <= fetch_next_pc;
      pc_valid   <= 1'b1;
      pred_taken <= fetch_taken;
    end else begin
      pc_valid   <= 1'b0;
    end
  end

  // RAS pointer and occupancy; a redirect empties the stack.
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      ras_sp_q  <= '0;
      ras_cnt_q <= '0;
    end else if (fetch_go) begin
      if (ras_pop && !ras_push) begin
        ras_sp_q  <= ras_sp_q - SP_ONE;
        ras_cnt_q <= ras_cnt_q - RAS_ONE;
      end else if (ras_push && !ras_pop) begin
        ras_sp_q <= ras_sp_q + SP_ONE;
        if (ras_cnt_q != RAS_FULL) ras_cnt_q <= ras_cnt_q + RAS_ONE;
      end
    end
  end

  // RAS storage: a push+pop replaces the popped slot with the new link,
  // a plain push overwrites the slot at sp (the oldest entry when full).
  always_ff @(posedge clk) begin
    if (!rst && !redirect && fetch_go && ras_push) begin
      if (ras_pop) ras_q[ras_sp_q - SP_ONE] <= pc_plus4;
      else         ras_q[ras_sp_q]          <= pc_plus4;
    end
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Self-checking bench for pc_predict_unit: directed scenarios compared with
// hand-derived constants, then a randomized run compared cycle by cycle with
// a behavioural model (integer counters, a bounded queue for the RAS).
module tb_pc_predict_unit;

  localparam int          IDX_W     = 8;
  localparam int          CNT_W     = 2;
  localparam int          RAS_DEPTH = 4;
  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam int          ENTRIES   = 1 << IDX_W;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;
  localparam int          CNT_HALF  = 1 << (CNT_W - 1);

  typedef enum int {K_OTHER, K_BR, K_JAL, K_JALR} kind_e;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [31:0] out_pc;
  logic        pc_valid;
  logic        pred_taken;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic        rob_valid;
  logic        rob_is_branch;
  logic [31:0] rob_pc;
  logic        rob_taken;
  logic        rob_mispredict;
  logic [31:0] rob_target;

  int errors = 0;
  int checks = 0;

  // Description of the instruction currently on fetch_inst.
  kind_e cur_kind;
  int    cur_rd;
  int    cur_rs1;
  int    cur_imm;

  // Behavioural model state and scoreboard.
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_taken;
  int          bht_m [ENTRIES];
  logic [31:0] ras_m [$];
  logic [33:0] exp_q [$];

  pc_predict_unit #(
    .RESET_PC  (RESET_PC),
    .IDX_W     (IDX_W),
    .CNT_W     (CNT_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .out_pc         (out_pc),
    .pc_valid       (pc_valid),
    .pred_taken     (pred_taken),
    .fetch_valid    (fetch_valid),
    .fetch_inst     (fetch_inst),
    .rob_valid      (rob_valid),
    .rob_is_branch  (rob_is_branch),
    .rob_pc         (rob_pc),
    .rob_taken      (rob_taken),
    .rob_mispredict (rob_mispredict),
    .rob_target     (rob_target)
  );

  // Clock and bounded-run watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- encoding helpers ----------------
  function automatic logic [31:0] encode(kind_e k, int rd, int rs1, int imm);
    logic [31:0] im;
    logic [4:0]  r;
    logic [4:0]  s;
    im = 32'(imm);
    r  = 5'(rd);
    s  = 5'(rs1);
    case (k)
      K_BR:    return {im[12], im[10:5], 5'd0, s, 3'b000, im[4:1], im[11], 7'b1100011};
      K_JAL:   return {im[20], im[10:1], im[11], im[19:12], r, 7'b1101111};
      K_JALR:  return {im[11:0], s, 3'b000, r, 7'b1100111};
      default: return {im[11:0], s, 3'b000, r, 7'b0010011};
    endcase
  endfunction

  function automatic bit link_reg(int r);
    return (r == 1) || (r == 5);
  endfunction

  function automatic int bidx(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  task automatic set_inst(kind_e k, int rd, int rs1, int imm);
    cur_kind   = k;
    cur_rd     = rd;
    cur_rs1    = rs1;
    cur_imm    = imm;
    fetch_inst = encode(k, rd, rs1, imm);
  endtask

  task automatic ras_push_m(logic [31:0] v);
    ras_m.push_back(v);
    if (ras_m.size() > RAS_DEPTH) void'(ras_m.pop_front());
  endtask

  // ---------------- driver: one clock with model update ----------------
  task automatic tick();
    logic [31:0] npc;
    logic        nv;
    logic        nt;
    int          ti;
    if (rst) begin
      npc = RESET_PC;
      nv  = 1'b0;
      nt  = 1'b0;
      ras_m.delete();
      foreach (bht_m[i]) bht_m[i] = CNT_HALF;
    end else begin
      npc = m_pc;
      nv  = 1'b0;
      nt  = m_taken;
      if (rob_valid && rob_mispredict) begin
        npc = rob_target;
        nv  = 1'b1;
        nt  = rob_taken;
        ras_m.delete();
      end else if (rdy && fetch_valid) begin
        nv  = 1'b1;
        npc = m_pc + 32'd4;
        nt  = 1'b0;
        case (cur_kind)
          K_BR: begin
            if (bht_m[bidx(m_pc)] >= CNT_HALF) begin
              npc = m_pc + 32'(cur_imm);
              nt  = 1'b1;
            end
          end
          K_JAL: begin
            npc = m_pc + 32'(cur_imm);
            nt  = 1'b1;
            if (link_reg(cur_rd)) ras_push_m(m_pc + 32'd4);
          end
          K_JALR: begin
            if (link_reg(cur_rs1) && cur_imm == 0 &&
                (cur_rd == 0 || (link_reg(cur_rd) && cur_rd != cur_rs1)) &&
                ras_m.size() > 0) begin
              npc = ras_m.pop_back();
              nt  = 1'b1;
            end
            if (link_reg(cur_rd)) ras_push_m(m_pc + 32'd4);
          end
          default: begin
          end
        endcase
      end
      if (rob_valid && rob_is_branch) begin
        ti = bidx(rob_pc);
        if (rob_taken) bht_m[ti] = (bht_m[ti] < CNT_MAX) ? bht_m[ti] + 1 : CNT_MAX;
        else           bht_m[ti] = (bht_m[ti] > 0) ? bht_m[ti] - 1 : 0;
      end
    end
    @(posedge clk);
    #1;
    m_pc    = npc;
    m_valid = nv;
    m_taken = nt;
    exp_q.push_back({nv, nt, npc});
  endtask

  task automatic idle();
    rdy            = 1'b1;
    fetch_valid    = 1'b0;
    rob_valid      = 1'b0;
    rob_is_branch  = 1'b0;
    rob_pc         = 32'h0;
    rob_taken      = 1'b0;
    rob_mispredict = 1'b0;
    rob_target     = 32'h0;
  endtask

  task automatic redirect_to(logic [31:0] addr);
    idle();
    rob_valid      = 1'b1;
    rob_mispredict = 1'b1;
    rob_target     = addr;
    tick();
    idle();
  endtask

  task automatic fetch_one(kind_e k, int rd, int rs1, int imm);
    idle();
    set_inst(k, rd, rs1, imm);
    fetch_valid = 1'b1;
    tick();
    idle();
  endtask

  task automatic commit_branch(logic [31:0] pc, logic tk);
    idle();
    rob_valid     = 1'b1;
    rob_is_branch = 1'b1;
    rob_pc        = pc;
    rob_taken     = tk;
    tick();
    idle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    set_inst(K_OTHER, 2, 0, 1);
    rst = 1'b1;
    tick();
    tick();
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", out_pc, 32'h0); end
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pc_valid); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b want 0", pred_taken); end
    rst = 1'b0;
    fetch_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (out_pc !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", i, out_pc, 32'(4 * i)); end
      checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL seq_valid%0d: got %b want 1", i, pc_valid); end
    end
    idle();
    tick();
    checks++; if (pc_valid !== 1'b0 || out_pc !== 32'hc) begin errors++; $display("FAIL hold: got valid=%b pc=%h want 0 0000000c", pc_valid, out_pc); end
  endtask

  task automatic test_bht();
    redirect_to(32'h20);
    checks++; if (out_pc !== 32'h20 || pc_valid !== 1'b1) begin errors++; $display("FAIL redir20: got pc=%h v=%b want 00000020 1", out_pc, pc_valid); end
    fetch_one(K_BR, 0, 1, -8);
    checks++; if (out_pc !== 32'h18) begin errors++; $display("FAIL beq_init_pc: got %h want 00000018", out_pc); end
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL beq_init_taken: got %b want 1", pred_taken); end
    commit_branch(32'h20, 1'b0);
    commit_branch(32'h20, 1'b0);
    redirect_to(32'h20);
    fetch_one(K_BR, 0, 1, -8);
    checks++; if (out_pc !== 32'h24) begin errors++; $display("FAIL beq_trained_pc: got %h want 00000024", out_pc); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL beq_trained_taken: got %b want 0", pred_taken); end
  endtask

  task automatic test_ras();
    redirect_to(32'h40);
    fetch_one(K_JAL, 1, 0, 32'h100);
    checks++; if (out_pc !== 32'h140) begin errors++; $display("FAIL jal_pc: got %h want 00000140", out_pc); end
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL jal_taken: got %b want 1", pred_taken); end
    fetch_one(K_JALR, 0, 1, 0);
    checks++; if (out_pc !== 32'h44) begin errors++; $display("FAIL ret_pc: got %h want 00000044", out_pc); end
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL ret_taken: got %b want 1", pred_taken); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] want;
    redirect_to(32'h1000);
    for (int i = 0; i < 5; i++) fetch_one(K_JAL, 1, 0, 32'h100);
    checks++; if (out_pc !== 32'h1500) begin errors++; $display("FAIL nest_pc: got %h want 00001500", out_pc); end
    for (int i = 0; i < 4; i++) begin
      want = 32'h1404 - 32'(i * 32'h100);
      fetch_one(K_JALR, 0, 1, 0);
      checks++; if (out_pc !== want || pred_taken !== 1'b1) begin errors++; $display("FAIL nest_ret%0d: got pc=%h t=%b want %h 1", i, out_pc, pred_taken, want); end
    end
    fetch_one(K_JALR, 0, 1, 0);
    checks++; if (out_pc !== 32'h1108) begin errors++; $display("FAIL empty_ret_pc: got %h want 00001108", out_pc); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL empty_ret_taken: got %b want 0", pred_taken); end
  endtask

  task automatic test_redirect();
    redirect_to(32'h100);
    fetch_one(K_JAL, 1, 0, 32'h20);
    idle();
    rdy = 1'b0;
    set_inst(K_JALR, 0, 1, 0);
    fetch_valid    = 1'b1;
    rob_valid      = 1'b1;
    rob_mispredict = 1'b1;
    rob_taken      = 1'b1;
    rob_target     = 32'h200;
    tick();
    idle();
    checks++; if (out_pc !== 32'h200) begin errors++; $display("FAIL redir_pc: got %h want 00000200", out_pc); end
    checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL redir_valid: got %b want 1", pc_valid); end
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL redir_taken: got %b want 1", pred_taken); end
    fetch_one(K_JALR, 0, 1, 0);
    checks++; if (out_pc !== 32'h204 || pred_taken !== 1'b0) begin errors++; $display("FAIL ras_flushed: got pc=%h t=%b want 00000204 0", out_pc, pred_taken); end
    // Lookup and training on the same entry in one cycle.
    redirect_to(32'h300);
    set_inst(K_BR, 0, 1, 32'h40);
    fetch_valid   = 1'b1;
    rob_valid     = 1'b1;
    rob_is_branch = 1'b1;
    rob_pc        = 32'h300;
    rob_taken     = 1'b0;
    tick();
    idle();
    checks++; if (out_pc !== 32'h340 || pred_taken !== 1'b1) begin errors++; $display("FAIL same_idx_old: got pc=%h t=%b want 00000340 1", out_pc, pred_taken); end
    redirect_to(32'h300);
    fetch_one(K_BR, 0, 1, 32'h40);
    checks++; if (out_pc !== 32'h304 || pred_taken !== 1'b0) begin errors++; $display("FAIL same_idx_new: got pc=%h t=%b want 00000304 0", out_pc, pred_taken); end
  endtask

  task automatic test_stall();
    redirect_to(32'h600);
    set_inst(K_OTHER, 2, 0, 1);
    rdy         = 1'b0;
    fetch_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rob_valid     = (i < 2);
      rob_is_branch = 1'b1;
      rob_pc        = 32'h600;
      rob_taken     = 1'b0;
      tick();
      checks++; if (out_pc !== 32'h600) begin errors++; $display("FAIL stall_pc%0d: got %h want 00000600", i, out_pc); end
      checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL stall_valid%0d: got %b want 0", i, pc_valid); end
    end
    fetch_one(K_BR, 0, 1, 32'h40);
    checks++; if (out_pc !== 32'h604 || pred_taken !== 1'b0) begin errors++; $display("FAIL stall_trained: got pc=%h t=%b want 00000604 0", out_pc, pred_taken); end
    checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL stall_resume: got %b want 1", pc_valid); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) commit_branch(32'h740, 1'b1);
    commit_branch(32'h740, 1'b0);
    redirect_to(32'h740);
    fetch_one(K_BR, 0, 1, -32'h40);
    checks++; if (out_pc !== 32'h700 || pred_taken !== 1'b1) begin errors++; $display("FAIL sat_high: got pc=%h t=%b want 00000700 1", out_pc, pred_taken); end
    commit_branch(32'h600, 1'b0);
    commit_branch(32'h600, 1'b0);
    commit_branch(32'h600, 1'b1);
    redirect_to(32'h600);
    fetch_one(K_BR, 0, 1, 32'h40);
    checks++; if (out_pc !== 32'h604 || pred_taken !== 1'b0) begin errors++; $display("FAIL sat_low: got pc=%h t=%b want 00000604 0", out_pc, pred_taken); end
    redirect_to(32'hffff_fff8);
    fetch_one(K_JAL, 0, 0, 32'h10);
    checks++; if (out_pc !== 32'h8 || pred_taken !== 1'b1) begin errors++; $display("FAIL wrap: got pc=%h t=%b want 00000008 1", out_pc, pred_taken); end
  endtask

  task automatic test_random();
    int          regs [4];
    logic [33:0] exp;
    kind_e       k;
    int          imm;
    regs = '{0, 1, 5, 2};
    exp_q.delete();
    for (int n = 0; n < 600; n++) begin
      idle();
      rdy         = ($urandom_range(0, 7) != 0);
      fetch_valid = ($urandom_range(0, 3) != 0);
      k = kind_e'($urandom_range(0, 3));
      case (k)
        K_BR:    imm = (int'($urandom_range(0, 64)) - 32) * 2;
        K_JAL:   imm = (int'($urandom_range(0, 512)) - 256) * 4;
        K_JALR:  imm = ($urandom_range(0, 3) == 0) ? 4 : 0;
        default: imm = int'($urandom_range(0, 100));
      endcase
      set_inst(k, regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)], imm);
      rob_valid      = ($urandom_range(0, 2) == 0);
      rob_is_branch  = $urandom_range(0, 1);
      rob_pc         = 32'($urandom_range(0, 15)) << 2;
      rob_taken      = $urandom_range(0, 1);
      rob_mispredict = ($urandom_range(0, 9) == 0);
      rob_target     = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      tick();
      exp = exp_q.pop_front();
      checks++; if (out_pc !== exp[31:0]) begin errors++; $display("FAIL rnd_pc@%0d: got %h want %h", n, out_pc, exp[31:0]); end
      checks++; if (pc_valid !== exp[33]) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", n, pc_valid, exp[33]); end
      checks++; if (pred_taken !== exp[32]) begin errors++; $display("FAIL rnd_taken@%0d: got %b want %b", n, pred_taken, exp[32]); end
    end
    idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst     = 1'b1;
    m_pc    = RESET_PC;
    m_valid = 1'b0;
    m_taken = 1'b0;
    idle();
    set_inst(K_OTHER, 0, 0, 0);
    test_reset();
    test_bht();
    test_ras();
    test_ras_overflow();
    test_redirect();
    test_stall();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
